pipe_issue_ctrl: RTL and testbench

- Producer/consumer end for the three-stage datapath pipeline, which is free-running with no stall input.
- Accepts a burst command (base operands, step, count) over a valid/ready handshake.
- Issues one operand pair per cycle into the pipeline and tracks in-flight slots with a latency shift register.
- Captures each returning result into a small FIFO, drained over a valid/ready result port. Credit-based issue guarantees no result is ever lost.

---
 rtl/pipe_issue_ctrl_if.sv | 39 +++
 rtl/pipe_issue_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_ctrl_if.sv
// Command, pipeline and result signals of the burst issue controller.
// The slave modport is the controller side; master is the driver side.
interface pipe_issue_ctrl_if #(
    parameter int DWIDTH = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [DWIDTH-1:0] cmd_op1_i;
    logic [DWIDTH-1:0] cmd_op2_i;
    logic [DWIDTH-1:0] cmd_step_i;
    logic [7:0]        cmd_count_i;
    logic [DWIDTH-1:0] pipe_op1_o;
    logic [DWIDTH-1:0] pipe_op2_o;
    logic [DWIDTH-1:0] pipe_res_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [DWIDTH-1:0] res_data_o;
    logic [7:0]        res_idx_o;
    logic              busy_o;
    logic              done_o;

    modport slave (
        input  cmd_valid_i, cmd_op1_i, cmd_op2_i,
        input  cmd_step_i, cmd_count_i,
        input  pipe_res_i, res_ready_i,
        output cmd_ready_o, pipe_op1_o, pipe_op2_o,
        output res_valid_o, res_data_o, res_idx_o,
        output busy_o, done_o
    );

    modport master (
        output cmd_valid_i, cmd_op1_i, cmd_op2_i,
        output cmd_step_i, cmd_count_i,
        output pipe_res_i, res_ready_i,
        input  cmd_ready_o, pipe_op1_o, pipe_op2_o,
        input  res_valid_o, res_data_o, res_idx_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Burst issue controller for a free-running fixed-latency pipeline.
// Credits cover in-flight slots plus FIFO entries, so results never drop.
module pipe_issue_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    pipe_issue_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] op2_q, op2_d;
    logic [DWIDTH-1:0] step_q, step_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        iss_q, iss_d;
    logic              done_q, done_d;

    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [7:0]          tag_q [PIPE_LAT];
    logic [7:0]          tag_d [PIPE_LAT];

    logic [DWIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [7:0]        mem_idx  [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       fcnt_q, fcnt_d;

    logic [OW-1:0] inflight;
    logic [OW-1:0] occ;
    logic          credit_ok;
    logic          cmd_ready;
    logic          accept;
    logic          issue;
    logic          push;
    logic [7:0]    push_tag;
    logic          fempty;
    logic          head_valid;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + OW'(vld_q[i]);
        end
    end

    assign occ       = OW'(fcnt_q) + inflight;
    assign credit_ok = occ < OW'(FIFO_DEPTH);
    assign cmd_ready = (state_q == S_IDLE) && !done_q;
    assign accept    = bus.cmd_valid_i && cmd_ready;
    assign issue     = (state_q == S_ISSUE) && credit_ok;

    assign push       = vld_q[PIPE_LAT-1];
    assign push_tag   = tag_q[PIPE_LAT-1];
    assign fempty     = (fcnt_q == '0);
    assign head_valid = !fempty || push;
    assign pop        = head_valid && bus.res_ready_i;
    // An empty FIFO forwards the exiting result straight to the head.
    assign wr_en      = push && !(pop && fempty);
    assign rd_en      = pop && !fempty;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        tag_d[0] = iss_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + (AW+1)'(1);
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op2_d   = op2_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        iss_d   = iss_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cmd_count_i == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        acc_d   = bus.cmd_op1_i;
                        op2_d   = bus.cmd_op2_i;
                        step_d  = bus.cmd_step_i;
                        cnt_d   = bus.cmd_count_i;
                        iss_d   = 8'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    acc_d = acc_q + step_q;
                    iss_d = iss_q + 8'd1;
                    if (iss_q + 8'd1 == cnt_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Done once nothing remains after this cycle's shift and pop.
                if (vld_d == '0 && fcnt_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op2_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            iss_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op2_q   <= op2_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            if (wr_en) begin
                wp_q <= wp_q + AW'(1);
            end
            if (rd_en) begin
                rp_q <= rp_q + AW'(1);
            end
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wp_q] <= bus.pipe_res_i;
            mem_idx[wp_q]  <= push_tag;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && fcnt_q == FULL));

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.pipe_op1_o  = issue ? acc_q : '0;
    assign bus.pipe_op2_o  = issue ? op2_q : '0;
    assign bus.res_valid_o = head_valid;
    assign bus.res_data_o  = !head_valid ? '0 :
                             fempty ? bus.pipe_res_i : mem_data[rp_q];
    assign bus.res_idx_o   = !head_valid ? '0 :
                             fempty ? push_tag : mem_idx[rp_q];
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = done_q;
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: occupancy-based reference model checked
// every cycle, plus literal expectations for the directed bursts.
module tb_pipe_issue_ctrl;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_issue_ctrl_if #(.DWIDTH(DW)) bus ();

    pipe_issue_ctrl #(
        .DWIDTH(DW), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // pipeline: res = op1 + op2, LAT cycles later
    logic [DW-1:0] pl [LAT];
    always @(posedge clk) begin
        pl[0] <= bus.pipe_op1_o + bus.pipe_op2_o;
        for (int i = 1; i < LAT; i++) pl[i] <= pl[i-1];
    end
    assign bus.pipe_res_i = pl[LAT-1];

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    i;
        int            av;
    } ent_t;

    ent_t          mq[$];
    int            m_ph;
    bit            m_done;
    bit            m_on = 1'b0;
    logic [DW-1:0] m_op1, m_op2, m_step;
    int            m_cnt, m_k;
    int            cyc = 0;

    logic [DW-1:0] pop_d[$];
    int            pop_i[$];
    int            n_done, busy_hi, first_iss, first_rv;
    int            last_pop, done_cyc;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic clr_logs();
        pop_d.delete();
        pop_i.delete();
        n_done    = 0;
        busy_hi   = 0;
        first_iss = -1;
        first_rv  = -1;
        last_pop  = -1;
        done_cyc  = -1;
    endtask

    always @(negedge clk) begin : cmp
        bit            iss, hv, pop, rdy, nd;
        logic [DW-1:0] eo1;
        cyc++;
        if (m_on) begin
            rdy = (m_ph == 0) && !m_done;
            iss = (m_ph == 1) && (mq.size() < DEPTH);
            hv  = (mq.size() > 0) && (mq[0].av <= cyc);
            eo1 = m_op1 + m_step * 32'(m_k);
            chk("cmd_ready", bus.cmd_ready_o, rdy);
            chk("busy", bus.busy_o, m_ph != 0);
            chk("done", bus.done_o, m_done);
            chk("pipe_op1", bus.pipe_op1_o, iss ? eo1 : '0);
            chk("pipe_op2", bus.pipe_op2_o, iss ? m_op2 : '0);
            chk("res_valid", bus.res_valid_o, hv);
            if (hv) begin
                chk("res_data", bus.res_data_o, mq[0].d);
                chk("res_idx", bus.res_idx_o, mq[0].i);
            end
            if (bus.done_o) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.busy_o) busy_hi++;
            if (iss && first_iss < 0) first_iss = cyc;
            if (bus.res_valid_o && first_rv < 0) first_rv = cyc;
            if (bus.res_valid_o && bus.res_ready_i) begin
                pop_d.push_back(bus.res_data_o);
                pop_i.push_back(int'(bus.res_idx_o));
                last_pop = cyc;
            end
            pop = hv && bus.res_ready_i;
            if (!rst) begin
                if (pop) void'(mq.pop_front());
                nd = 1'b0;
                case (m_ph)
                    0: if (bus.cmd_valid_i && rdy) begin
                        if (bus.cmd_count_i == 8'd0) begin
                            nd = 1'b1;
                        end else begin
                            m_op1  = bus.cmd_op1_i;
                            m_op2  = bus.cmd_op2_i;
                            m_step = bus.cmd_step_i;
                            m_cnt  = int'(bus.cmd_count_i);
                            m_k    = 0;
                            m_ph   = 1;
                        end
                    end
                    1: if (iss) begin
                        mq.push_back(ent_t'{d: eo1 + m_op2,
                                            i: 8'(m_k),
                                            av: cyc + LAT});
                        m_k++;
                        if (m_k == m_cnt) m_ph = 2;
                    end
                    default: if (mq.size() == 0) begin
                        m_ph = 0;
                        nd   = 1'b1;
                    end
                endcase
                m_done = nd;
            end
        end
        if (rst) begin
            mq.delete();
            m_ph   = 0;
            m_done = 1'b0;
            m_k    = 0;
            m_cnt  = 0;
            m_op1  = '0;
            m_op2  = '0;
            m_step = '0;
            m_on   = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] s, input logic [7:0] c);
        int n = 0;
        bus.cmd_op1_i   = a;
        bus.cmd_op2_i   = b;
        bus.cmd_step_i  = s;
        bus.cmd_count_i = c;
        bus.cmd_valid_i = 1'b1;
        while (!bus.cmd_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept_wait", bus.cmd_ready_o, 1'b1);
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            tick();
            n++;
        end
        chk(nm, bus.done_o, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op1_i   = '0;
        bus.cmd_op2_i   = '0;
        bus.cmd_step_i  = '0;
        bus.cmd_count_i = '0;
        bus.res_ready_i = 1'b0;
        clr_logs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // 1: reset / idle
        chk("t1_ready", bus.cmd_ready_o, 1'b1);
        chk("t1_valid", bus.res_valid_o, 1'b0);
        chk("t1_busy", bus.busy_o, 1'b0);
        chk("t1_done", bus.done_o, 1'b0);
        chk("t1_op1", bus.pipe_op1_o, '0);

        // 2: streaming burst
        clr_logs();
        bus.res_ready_i = 1'b1;
        send_cmd(32'd10, 32'd5, 32'd1, 8'd4);
        wait_done(40, "t2_done_wait");
        chk("t2_npop", pop_d.size(), 4);
        for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
            chk("t2_data", pop_d[i], 32'd15 + 32'(i));
            chk("t2_idx", pop_i[i], i);
        end
        chk("t2_latency", first_rv - first_iss, 3);
        chk("t2_ndone", n_done, 1);
        chk("t2_done_after_pop", done_cyc - last_pop, 1);

        // 3: back-pressure and credit stall
        clr_logs();
        bus.res_ready_i = 1'b0;
        send_cmd(32'd100, 32'd0, 32'd2, 8'd8);
        repeat (15) tick();
        chk("t3_issued_stall", m_k, 4);
        chk("t3_head_valid", bus.res_valid_o, 1'b1);
        chk("t3_no_pop", pop_d.size(), 0);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        repeat (10) tick();
        chk("t3_issued_one_more", m_k, 5);
        bus.res_ready_i = 1'b1;
        wait_done(60, "t3_done_wait");
        chk("t3_npop", pop_d.size(), 8);
        for (int i = 0; i < 8 && i < pop_d.size(); i++) begin
            chk("t3_data", pop_d[i], 32'd100 + 32'(2 * i));
            chk("t3_idx", pop_i[i], i);
        end

        // 4: op1 accumulator wrap
        clr_logs();
        send_cmd(32'hFFFF_FFFE, 32'd0, 32'd1, 8'd3);
        wait_done(40, "t4_done_wait");
        chk("t4_npop", pop_d.size(), 3);
        if (pop_d.size() == 3) begin
            chk("t4_r0", pop_d[0], 32'hFFFF_FFFE);
            chk("t4_r1", pop_d[1], 32'hFFFF_FFFF);
            chk("t4_r2", pop_d[2], 32'h0000_0000);
        end

        // 5: zero-length burst
        clr_logs();
        send_cmd(32'd1, 32'd2, 32'd3, 8'd0);
        chk("t5_done_next", bus.done_o, 1'b1);
        chk("t5_busy", bus.busy_o, 1'b0);
        tick();
        tick();
        chk("t5_ndone", n_done, 1);
        chk("t5_busy_cycles", busy_hi, 0);
        chk("t5_npop", pop_d.size(), 0);

        // 6: reset mid-burst, then a clean burst
        clr_logs();
        send_cmd(32'd50, 32'd1, 32'd1, 8'd6);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ready", bus.cmd_ready_o, 1'b1);
        chk("t6_busy", bus.busy_o, 1'b0);
        chk("t6_valid", bus.res_valid_o, 1'b0);
        repeat (6) tick();
        chk("t6_no_stale", pop_d.size(), 0);
        send_cmd(32'd1, 32'd1, 32'd1, 8'd2);
        wait_done(40, "t6_done_wait");
        chk("t6_npop", pop_d.size(), 2);
        if (pop_d.size() == 2) begin
            chk("t6_r0", pop_d[0], 32'd2);
            chk("t6_r1", pop_d[1], 32'd3);
            chk("t6_i1", pop_i[1], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
